// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: reads a multiplexed active-low 7-seg bus back into per-digit BCD
//   clk, rst     : clock, async active-high reset
//   seg          : active-low segments, bit0=a .. bit6=g
//   dig_sel      : active-low digit enables, one-hot when driving
//   digits       : decoded BCD, digit i at [4i+3:4i]
//   digit_valid  : digit i captured since reset
//   err          : last capture of digit i was an unknown pattern
//   frame_done   : one-cycle pulse when every digit has been captured since the last pulse
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    frame_done
);
    typedef enum logic [1:0] {WAIT_SEL, SETTLE, HELD} state_t;
    state_t state, nxt;
    logic [6:0] seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] sel_s1, sel_s2, act, mask, mask_nx;
    logic [NUM_DIGITS+6:0] sample, prev;
    logic [CNT_W-1:0] cnt;
    logic changed, one_hot, cap, dec_err;
    logic [3:0] dec_nib;
    assign sample  = {sel_s2, seg_s2};
    assign changed = sample != prev;
    assign act     = ~sel_s2;
    assign one_hot = (act != '0) && ((act & (act - 1'b1)) == '0);
    assign mask_nx = mask | act;
    always_comb begin
        {dec_err, dec_nib} = 5'h1E;
        case (seg_s2)
            7'b1000000: {dec_err, dec_nib} = 5'h00;
            7'b1111001: {dec_err, dec_nib} = 5'h01;
            7'b0100100: {dec_err, dec_nib} = 5'h02;
            7'b0110000: {dec_err, dec_nib} = 5'h03;
            7'b0011001: {dec_err, dec_nib} = 5'h04;
            7'b0010010: {dec_err, dec_nib} = 5'h05;
            7'b0000010: {dec_err, dec_nib} = 5'h06;
            7'b1111000: {dec_err, dec_nib} = 5'h07;
            7'b0000000: {dec_err, dec_nib} = 5'h08;
            7'b0010000: {dec_err, dec_nib} = 5'h09;
            7'b0111111: {dec_err, dec_nib} = 5'h0F;
            default:    {dec_err, dec_nib} = 5'h1E;
        endcase
    end
    // capture fires on the edge where the sample has been steady for STABLE_CYCLES
    always_comb begin
        nxt = state;
        cap = 1'b0;
        case (state)
            WAIT_SEL: nxt = one_hot ? SETTLE : WAIT_SEL;
            SETTLE: begin
                if (!one_hot) nxt = WAIT_SEL;
                else if (!changed && cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    cap = 1'b1;
                    nxt = HELD;
                end
            end
            HELD:    nxt = changed ? (one_hot ? SETTLE : WAIT_SEL) : HELD;
            default: nxt = WAIT_SEL;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1      <= '0;
            seg_s2      <= '0;
            sel_s1      <= '0;
            sel_s2      <= '0;
            prev        <= '0;
            cnt         <= '0;
            state       <= WAIT_SEL;
            mask        <= '0;
            frame_done  <= 1'b0;
            digits      <= '1;
            digit_valid <= '0;
            err         <= '0;
        end else begin
            seg_s1     <= seg;
            seg_s2     <= seg_s1;
            sel_s1     <= dig_sel;
            sel_s2     <= sel_s1;
            prev       <= sample;
            cnt        <= changed ? '0 : (cnt == CNT_W'(STABLE_CYCLES) ? cnt : cnt + 1'b1);
            state      <= nxt;
            frame_done <= cap && (mask_nx == '1);
            if (cap) mask <= (mask_nx == '1) ? '0 : mask_nx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap && act[i]) begin
                    digits[4*i +: 4] <= dec_nib;
                    err[i]           <= dec_err;
                    digit_valid[i]   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed scoreboard bench for seg7_scan_reader
module tb_seg7_scan_reader;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S8 = 7'b0000000, S9 = 7'b0010000;
    localparam logic [6:0] DASH = 7'b0111111, BLANK = 7'b1111111;
    typedef struct packed {
        logic [23:0] d;
        logic [5:0]  v;
        logic [5:0]  e;
    } snap_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [6:0] seg = BLANK;
    logic [5:0] dig_sel = 6'h3F;
    logic [23:0] digits;
    logic [5:0] digit_valid, err;
    logic frame_done;
    int compared = 0, mism = 0, fd_cnt = 0, fd0;
    logic [23:0] exp_dig = 24'hFFFFFF;
    logic [5:0] exp_val = '0, exp_err = '0;
    snap_t q[$];
    seg7_scan_reader dut (
        .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel),
        .digits(digits), .digit_valid(digit_valid), .err(err), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mism++;
            $error("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask
    task automatic push();
        snap_t s;
        s = {exp_dig, exp_val, exp_err};
        q.push_back(s);
    endtask
    task automatic pop_chk(input string tag);
        snap_t s;
        if (q.size() == 0) begin
            chk({tag, " queue"}, 0, 1);
            return;
        end
        s = q.pop_front();
        chk({tag, " digits"}, digits, s.d);
        chk({tag, " valid"}, digit_valid, s.v);
        chk({tag, " err"}, err, s.e);
    endtask
    task automatic drive(input int idx, input logic [6:0] s, input logic [3:0] nib, input logic e);
        dig_sel = ~(6'b1 << idx);
        seg = s;
        exp_dig[4*idx +: 4] = nib;
        exp_err[idx] = e;
        exp_val[idx] = 1'b1;
        push();
    endtask
    task automatic step(input string tag, input int idx, input logic [6:0] s, input logic [3:0] nib, input logic e);
        drive(idx, s, nib, e);
        tick(8);
        pop_chk(tag);
    endtask
    task automatic reset_model();
        exp_dig = 24'hFFFFFF;
        exp_val = '0;
        exp_err = '0;
    endtask
    initial begin
        tick(3);
        chk("rst digits", digits, 24'hFFFFFF);
        chk("rst valid", digit_valid, 0);
        chk("rst frame", frame_done, 0);
        rst = 1'b0;
        // idle bus: no captures, no frame pulse
        push();
        tick(50);
        pop_chk("idle");
        chk("idle frames", fd_cnt, 0);
        // exact latency: visible after edge t+6, not after t+5
        drive(0, S2, 4'h2, 1'b0);
        tick(6);
        chk("lat early digits", digits, 24'hFFFFFF);
        chk("lat early valid", digit_valid, 0);
        tick(1);
        pop_chk("lat");
        // full scan; digit 0 already counted in the mask
        fd0 = fd_cnt;
        step("scan0", 0, S1, 4'h1, 1'b0);
        step("scan1", 1, S2, 4'h2, 1'b0);
        step("scan2", 2, S3, 4'h3, 1'b0);
        step("scan3", 3, S4, 4'h4, 1'b0);
        step("scan4", 4, S5, 4'h5, 1'b0);
        chk("scan no early frame", fd_cnt, fd0);
        step("scan5", 5, S9, 4'h9, 1'b0);
        chk("scan frame", fd_cnt, fd0 + 1);
        chk("scan value", digits, 24'h954321);
        // dash then unknown pattern on digit 2
        step("dash", 2, DASH, 4'hF, 1'b0);
        step("blank", 2, BLANK, 4'hE, 1'b1);
        // glitching segments and double selects never capture
        fd0 = fd_cnt;
        push();
        dig_sel = 6'b111101;
        for (int k = 0; k < 14; k++) begin
            seg = k[0] ? S8 : S0;
            tick(3);
        end
        dig_sel = 6'b111100;
        seg = S0;
        tick(20);
        dig_sel = 6'h3F;
        tick(10);
        pop_chk("glitch");
        chk("glitch frames", fd_cnt, fd0);
        // partial frame, then async reset mid-settle
        step("part0", 0, S5, 4'h5, 1'b0);
        step("part1", 1, S4, 4'h4, 1'b0);
        dig_sel = 6'b110111;
        seg = S0;
        tick(4);
        #2 rst = 1'b1;
        #1;
        chk("async digits", digits, 24'hFFFFFF);
        chk("async valid", digit_valid, 0);
        chk("async err", err, 0);
        chk("async frame", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        dig_sel = 6'h3F;
        seg = BLANK;
        reset_model();
        tick(4);
        fd0 = fd_cnt;
        step("post2", 2, S2, 4'h2, 1'b0);
        step("post3", 3, S3, 4'h3, 1'b0);
        step("post4", 4, S4, 4'h4, 1'b0);
        step("post5", 5, S5, 4'h5, 1'b0);
        chk("post no early frame", fd_cnt, fd0);
        step("post0", 0, S0, 4'h0, 1'b0);
        step("post1", 1, S1, 4'h1, 1'b0);
        chk("post frame", fd_cnt, fd0 + 1);
        chk("post value", digits, 24'h543210);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
